// File: rtl/systolic_gemm_ctrl_pkg.sv
// rtl/systolic_gemm_ctrl_pkg.sv - shared state encoding and tile timing helpers for the GEMM sequencer
package systolic_gemm_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DRAIN} state_t;

  // Cycles from the last operand beat until the far corner PE holds its final sum.
  function automatic int flush_len(input int rows, input int cols, input int pe_lat);
    return (rows - 1) + (cols - 1) + pe_lat;
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_gemm_ctrl_if.sv
// rtl/systolic_gemm_ctrl_if.sv - operand, result and control handshake bundle of the GEMM sequencer
interface systolic_gemm_ctrl_if
  import systolic_gemm_ctrl_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int K_MAX = 256
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = sel_width(ROWS);

  logic            start;
  logic [KW-1:0]   k_len;
  logic            data_valid;
  logic            data_ready;
  logic [ROWS-1:0] in_valid_A;
  logic [COLS-1:0] in_valid_B;
  logic            acc_clear;
  logic [RW-1:0]   row_sel;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start, k_len, data_valid, out_ready,
    input  data_ready, in_valid_A, in_valid_B, acc_clear, row_sel, out_valid, busy, done, err
  );

  modport slave (
    input  start, k_len, data_valid, out_ready,
    output data_ready, in_valid_A, in_valid_B, acc_clear, row_sel, out_valid, busy, done, err
  );

endinterface

// File: rtl/systolic_gemm_ctrl_skew_pipe.sv
// rtl/systolic_gemm_ctrl_skew_pipe.sv - 1-bit tapped delay line, lane i is the input delayed i cycles
module systolic_gemm_ctrl_skew_pipe #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [LANES-1:0] dout
);

  generate
    if (LANES == 1) begin : g_single
      assign dout = din;
    end else begin : g_multi
      logic [LANES-1:1] dly;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly <= '0;
        end else begin
          dly[1] <= din;
          for (int i = 2; i < LANES; i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end

      assign dout = {dly, din};
    end
  endgenerate

endmodule

// File: rtl/systolic_gemm_ctrl.sv
// rtl/systolic_gemm_ctrl.sv - output-stationary systolic GEMM tile sequencer
// Runs CLEAR, K operand beats, a wavefront flush and a back-pressured per-row drain.
module systolic_gemm_ctrl
  import systolic_gemm_ctrl_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int K_MAX  = 256,
  parameter int PE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_gemm_ctrl_if.slave  bus
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = sel_width(ROWS);
  localparam int F  = flush_len(ROWS, COLS, PE_LAT);
  localparam int FW = $clog2(F + 1);
  localparam logic [KW:0]   KMAX_W   = (KW + 1)'(K_MAX);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [FW-1:0] LAST_FL  = FW'(F - 1);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_lat;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row_sel_q;
  logic            done_q;
  logic            err_q;

  logic            legal;
  logic            beat;
  logic            last_beat;
  logic            flush_end;
  logic            row_acc;
  logic            last_row;
  logic            ready_c;
  logic            clear_c;
  logic            valid_c;

  assign legal     = (bus.k_len != '0) && ({1'b0, bus.k_len} <= KMAX_W);
  assign beat      = ready_c && bus.data_valid;
  assign last_beat = beat && (beat_cnt == k_lat - KW'(1));
  assign flush_end = (state_q == FLUSH) && (flush_cnt == LAST_FL);
  assign row_acc   = valid_c && bus.out_ready;
  assign last_row  = row_acc && (row_sel_q == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    clear_c = 1'b0;
    valid_c = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.start && legal) state_d = CLEAR;
      CLEAR: begin
        clear_c = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        ready_c = 1'b1;
        if (last_beat) state_d = FLUSH;
      end
      FLUSH: if (flush_end) state_d = DRAIN;
      DRAIN: begin
        valid_c = 1'b1;
        if (last_row) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_sel_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start && legal) k_lat <= bus.k_len;

      if (state_q == CLEAR)  beat_cnt <= '0;
      else if (beat)         beat_cnt <= beat_cnt + KW'(1);

      // Runs only while flushing; the wrap past LAST_FL is never observed.
      if (state_q == FLUSH)  flush_cnt <= flush_cnt + FW'(1);
      else                   flush_cnt <= '0;

      if (last_row)          row_sel_q <= '0;
      else if (row_acc)      row_sel_q <= row_sel_q + RW'(1);

      done_q <= last_row;
      err_q  <= (state_q == IDLE) && bus.start && !legal;
    end
  end

  systolic_gemm_ctrl_skew_pipe #(.LANES(ROWS)) u_skew_a (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (beat),
    .dout  (bus.in_valid_A)
  );

  systolic_gemm_ctrl_skew_pipe #(.LANES(COLS)) u_skew_b (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (beat),
    .dout  (bus.in_valid_B)
  );

  assign bus.data_ready = ready_c;
  assign bus.acc_clear  = clear_c;
  assign bus.out_valid  = valid_c;
  assign bus.row_sel    = row_sel_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_systolic_gemm_ctrl.sv
// tb/tb_systolic_gemm_ctrl.sv - self-checking bench for systolic_gemm_ctrl
// Timeline reference model: tile events derived from start/beat/accept cycle arithmetic.
module tb_systolic_gemm_ctrl;
  import systolic_gemm_ctrl_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 3;
  localparam int K_MAX = 256;
  localparam int F     = flush_len(ROWS, COLS, 1);
  localparam int F1    = flush_len(1, 1, 1);
  localparam int MAXC  = 400;
  localparam int LIM   = 2 * MAXC;

  typedef logic [14:0] obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bit          s_start [MAXC];
  logic [8:0]  s_k     [MAXC];
  bit          s_dv    [MAXC];
  bit          s_or    [MAXC];
  obs_t        exp_t   [MAXC];
  obs_t        got_t   [MAXC];

  always #5 clk = ~clk;

  systolic_gemm_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) bus ();
  systolic_gemm_ctrl_if #(.ROWS(1), .COLS(1), .K_MAX(K_MAX)) bus1 ();

  systolic_gemm_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .PE_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  systolic_gemm_ctrl #(.ROWS(1), .COLS(1), .K_MAX(K_MAX), .PE_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  function automatic obs_t observe();
    return {bus.data_ready, bus.acc_clear, bus.out_valid, bus.busy, bus.done, bus.err,
            bus.row_sel, bus.in_valid_A, bus.in_valid_B};
  endfunction

  function automatic bit dv_at(input int u);
    return (u < MAXC) ? s_dv[u] : 1'b1;
  endfunction

  function automatic bit or_at(input int u);
    return (u < MAXC) ? s_or[u] : 1'b1;
  endfunction

  task automatic clear_stim(input bit dv_def, input bit or_def);
    for (int c = 0; c < MAXC; c++) begin
      s_start[c] = 1'b0;
      s_k[c]     = 9'd0;
      s_dv[c]    = dv_def;
      s_or[c]    = or_def;
    end
  endtask

  // Walks the stimulus: each accepted start spawns a tile whose events are placed by counting beats and accepts.
  task automatic build_model();
    bit e_rdy [LIM], e_clr [LIM], e_ova [LIM], e_bsy [LIM], e_dn [LIM], e_err [LIM], beat [LIM];
    int rs [LIM];
    int free_at, u, got, tl, rows, ta, k;
    logic [3:0] iva;
    logic [2:0] ivb;
    free_at = 0;
    for (int c = 0; c < LIM; c++) begin
      e_rdy[c] = 0; e_clr[c] = 0; e_ova[c] = 0; e_bsy[c] = 0;
      e_dn[c] = 0; e_err[c] = 0; beat[c] = 0; rs[c] = 0;
    end
    for (int t = 0; t < MAXC; t++) begin
      if (t >= free_at && s_start[t]) begin
        k = int'(s_k[t]);
        if (k == 0 || k > K_MAX) begin
          e_err[t+1] = 1'b1;
        end else begin
          e_clr[t+1] = 1'b1;
          u = t + 2; got = 0; tl = u;
          while (got < k && u < LIM - 100) begin
            e_rdy[u] = 1'b1;
            if (dv_at(u)) begin beat[u] = 1'b1; got++; tl = u; end
            u++;
          end
          u = tl + F + 1; rows = 0; ta = u;
          while (rows < ROWS && u < LIM - 2) begin
            e_ova[u] = 1'b1;
            rs[u] = rows;
            if (or_at(u)) begin rows++; ta = u; end
            u++;
          end
          for (int c = t + 1; c <= ta; c++) e_bsy[c] = 1'b1;
          e_dn[ta+1] = 1'b1;
          free_at = ta + 1;
        end
      end
    end
    for (int t = 0; t < MAXC; t++) begin
      for (int i = 0; i < 4; i++) iva[i] = (t >= i) ? beat[t-i] : 1'b0;
      for (int j = 0; j < 3; j++) ivb[j] = (t >= j) ? beat[t-j] : 1'b0;
      exp_t[t] = {e_rdy[t], e_clr[t], e_ova[t], e_bsy[t], e_dn[t], e_err[t], 2'(rs[t]), iva, ivb};
    end
  endtask

  task automatic run_capture(input int n, input string name);
    int w;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus.start      = s_start[c];
      bus.k_len      = s_k[c];
      bus.data_valid = s_dv[c];
      bus.out_ready  = s_or[c];
      @(negedge clk);
      got_t[c] = observe();
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.data_valid = 1'b1; bus.out_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 300) begin @(negedge clk); w++; end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL %s idle_timeout: busy=%b required 0", name, bus.busy);
    end
    bus.data_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (observe() !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int last_b, first_v, nclr;
    clear_stim(1'b1, 1'b1);
    s_start[0] = 1'b1; s_k[0] = 9'd5;
    build_model();
    run_capture(40, "nominal");
    last_b = -1; first_v = -1; nclr = 0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (got_t[c] !== exp_t[c]) begin
        errors++;
        $display("FAIL nominal cycle %0d: got %b required %b", c, got_t[c], exp_t[c]);
      end
      if (got_t[c][3]) last_b = c;
      if (got_t[c][12] && first_v < 0) first_v = c;
      if (got_t[c][13]) nclr++;
    end
    checks++;
    if (first_v - last_b !== F + 1) begin
      errors++;
      $display("FAIL nominal_latency: got %0d required %0d", first_v - last_b, F + 1);
    end
    checks++;
    if (nclr !== 1) begin
      errors++;
      $display("FAIL nominal_clear_pulses: got %0d required 1", nclr);
    end
  endtask

  task automatic test_input_stalls();
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int nb;
    clear_stim(1'b0, 1'b1);
    s_start[0] = 1'b1; s_k[0] = 9'd4;
    for (int i = 0; i < 7; i++) s_dv[2+i] = pat[i];
    build_model();
    run_capture(40, "stalls");
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (got_t[c] !== exp_t[c]) begin
        errors++;
        $display("FAIL stalls cycle %0d: got %b required %b", c, got_t[c], exp_t[c]);
      end
      if (got_t[c][2]) nb++;
    end
    checks++;
    if (nb !== 4) begin
      errors++;
      $display("FAIL stalls_lane_b2_beats: got %0d required 4", nb);
    end
  endtask

  task automatic test_backpressure();
    int held;
    clear_stim(1'b1, 1'b1);
    s_start[0] = 1'b1; s_k[0] = 9'd3;
    // Beats land in cycles 2..4, so the drain presents row 2 at cycle 13.
    for (int c = 13; c < 18; c++) s_or[c] = 1'b0;
    build_model();
    run_capture(40, "backpressure");
    held = 0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (got_t[c] !== exp_t[c]) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got %b required %b", c, got_t[c], exp_t[c]);
      end
      if (got_t[c][12] && got_t[c][8:7] == 2'd2) held++;
    end
    checks++;
    if (held !== 6) begin
      errors++;
      $display("FAIL backpressure_row2_hold: got %0d required 6", held);
    end
  endtask

  task automatic test_illegal_start();
    clear_stim(1'b1, 1'b1);
    s_start[0] = 1'b1; s_k[0] = 9'd0;
    s_start[3] = 1'b1; s_k[3] = 9'(K_MAX + 1);
    build_model();
    run_capture(8, "illegal");
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (got_t[c] !== exp_t[c]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %b required %b", c, got_t[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int ndone;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.k_len = 9'd5; bus.data_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL midload_in_load: data_ready=%b required 1", bus.data_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (observe() !== 15'd0) begin
      errors++;
      $display("FAIL midload_reset_outputs: got %b required 0", observe());
    end
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin @(negedge clk); if (bus.done || bus.busy) ndone++; end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL midload_no_done: busy_or_done cycles %0d required 0", ndone);
    end
    bus.data_valid = 1'b0; bus.out_ready = 1'b0;
    clear_stim(1'b1, 1'b1);
    s_start[0] = 1'b1; s_k[0] = 9'd1;
    build_model();
    run_capture(25, "after_reset");
    for (int c = 0; c < 25; c++) begin
      checks++;
      if (got_t[c] !== exp_t[c]) begin
        errors++;
        $display("FAIL after_reset cycle %0d: got %b required %b", c, got_t[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stim(1'b1, 1'b1);
    for (int c = 0; c < 60; c++) begin s_start[c] = 1'b1; s_k[c] = 9'd1; end
    build_model();
    run_capture(70, "back_to_back");
    for (int c = 0; c < 70; c++) begin
      checks++;
      if (got_t[c] !== exp_t[c]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", c, got_t[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    clear_stim(1'b1, 1'b1);
    for (int c = 0; c < 250; c++) begin
      if (c < 200) s_start[c] = ($urandom % 6) == 0;
      r = $urandom % 10;
      s_k[c]  = (r == 0) ? 9'd0 : (r == 1) ? 9'(K_MAX + 1) : 9'(1 + $urandom % 8);
      s_dv[c] = ($urandom % 4) != 0;
      s_or[c] = ($urandom % 3) != 0;
    end
    build_model();
    run_capture(330, "random");
    for (int c = 0; c < 330; c++) begin
      checks++;
      if (got_t[c] !== exp_t[c]) begin
        errors++;
        $display("FAIL random cycle %0d: got %b required %b", c, got_t[c], exp_t[c]);
      end
    end
  endtask

  // 1x1 array with start held high: tiles repeat with period F1+4 cycles.
  task automatic test_min_array();
    localparam int P = F1 + 4;
    logic [4:0] g, e;
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.k_len = 9'd1; bus1.data_valid = 1'b1; bus1.out_ready = 1'b1;
    for (int c = 0; c < 3 * P; c++) begin
      @(negedge clk);
      g = {bus1.acc_clear, bus1.data_ready, bus1.in_valid_A[0], bus1.out_valid, bus1.done};
      e = {c % P == 1, c % P == 2, c % P == 2, c % P == F1 + 3, c > 0 && c % P == 0};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL min_array cycle %0d: got %b required %b", c, g, e);
      end
      @(posedge clk); #1;
    end
    bus1.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.k_len = '0; bus.data_valid = 1'b0; bus.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.k_len = '0; bus1.data_valid = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_input_stalls();
    test_backpressure();
    test_illegal_start();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    test_min_array();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
